// File: rtl/coder_pkg.sv
// coder_pkg: shared types for the quadrature step generator.
// Holds the FSM state type, the four (A,B) quadrature encodings and the
// helper that advances the quadrature state by one transition.
package coder_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } coder_state_e;

    // (A,B) encodings, A in bit 1, B in bit 0.
    localparam logic [1:0] QuadS0 = 2'b00;
    localparam logic [1:0] QuadS1 = 2'b01;
    localparam logic [1:0] QuadS2 = 2'b11;
    localparam logic [1:0] QuadS3 = 2'b10;

    // Plus walks S0->S1->S2->S3->S0, minus walks the same ring backwards.
    function automatic logic [1:0] quad_next(input logic [1:0] ab, input logic minus);
        logic [1:0] nxt;
        case (ab)
            QuadS0:  nxt = minus ? QuadS3 : QuadS1;
            QuadS1:  nxt = minus ? QuadS0 : QuadS2;
            QuadS2:  nxt = minus ? QuadS1 : QuadS3;
            default: nxt = minus ? QuadS2 : QuadS0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/coder_gen_if.sv
// coder_gen_if: request/status bundle of the quadrature step generator.
// o_coder_Z exists only when CODER_GEN_INDEX_EN is defined.
interface coder_gen_if #(
    parameter int unsigned P_PEND_W   = 8,
    parameter int unsigned P_PERIOD_W = 16
);
    logic                       i_en;
    logic                       i_plus_pulse;
    logic                       i_minus_pulse;
    logic [P_PERIOD_W-1:0]      i_edge_period;
    logic                       i_ovf_clr;
    logic                       o_coder_A;
    logic                       o_coder_B;
`ifdef CODER_GEN_INDEX_EN
    logic                       o_coder_Z;
`endif
    logic                       o_busy;
    logic signed [P_PEND_W-1:0] o_pending;
    logic                       o_overflow;

`ifdef CODER_GEN_INDEX_EN
    modport master (
        output i_en, i_plus_pulse, i_minus_pulse, i_edge_period, i_ovf_clr,
        input  o_coder_A, o_coder_B, o_coder_Z, o_busy, o_pending, o_overflow
    );
    modport slave (
        input  i_en, i_plus_pulse, i_minus_pulse, i_edge_period, i_ovf_clr,
        output o_coder_A, o_coder_B, o_coder_Z, o_busy, o_pending, o_overflow
    );
`else
    modport master (
        output i_en, i_plus_pulse, i_minus_pulse, i_edge_period, i_ovf_clr,
        input  o_coder_A, o_coder_B, o_busy, o_pending, o_overflow
    );
    modport slave (
        input  i_en, i_plus_pulse, i_minus_pulse, i_edge_period, i_ovf_clr,
        output o_coder_A, o_coder_B, o_busy, o_pending, o_overflow
    );
`endif

endinterface

// File: rtl/coder_gen_pend.sv
// coder_gen_pend: saturating signed count of requested-but-unstarted steps.
// Saturates symmetrically at +/-(2^(P_PEND_W-1)-1) and raises a sticky overflow.
module coder_gen_pend #(
    parameter int unsigned P_PEND_W = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_plus,
    input  logic                       i_minus,
    input  logic                       i_take,
    input  logic                       i_ovf_clr,
    output logic signed [P_PEND_W-1:0] o_pending,
    output logic                       o_overflow
);
    // Two guard bits hold any pending +/- 2 without wrapping.
    localparam int unsigned SumW = P_PEND_W + 2;
    localparam logic signed [SumW-1:0] PendMax = SumW'((1 << (P_PEND_W - 1)) - 1);
    localparam logic signed [SumW-1:0] PendMin = -PendMax;

    logic signed [P_PEND_W-1:0] pending_q, pending_d;
    logic                       overflow_q, overflow_d;
    logic signed [SumW-1:0]     req_delta;
    logic signed [SumW-1:0]     take_delta;
    logic signed [SumW-1:0]     sum;

    // Combine request and step-start adjustment, then clamp
    always_comb begin
        req_delta = '0;
        if (i_plus && !i_minus) begin
            req_delta = SumW'(1);
        end else if (i_minus && !i_plus) begin
            req_delta = SumW'(-1);
        end

        // A started step moves the count one toward zero.
        take_delta = '0;
        if (i_take) begin
            take_delta = (pending_q > 0) ? SumW'(-1) : SumW'(1);
        end

        sum        = SumW'(pending_q) + req_delta + take_delta;
        pending_d  = sum[P_PEND_W-1:0];
        overflow_d = overflow_q;
        if (i_ovf_clr) begin
            overflow_d = 1'b0;
        end
        // A fresh saturation wins over a simultaneous clear.
        if (sum > PendMax) begin
            pending_d  = PendMax[P_PEND_W-1:0];
            overflow_d = 1'b1;
        end else if (sum < PendMin) begin
            pending_d  = PendMin[P_PEND_W-1:0];
            overflow_d = 1'b1;
        end
    end

    // Counter and sticky flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_pending  = pending_q;
    assign o_overflow = overflow_q;

endmodule

// File: rtl/coder_gen.sv
// coder_gen: converts plus/minus step requests into quadrature A/B edges.
// Define CODER_GEN_INDEX_EN to add the position counter and o_coder_Z index pulse.
module coder_gen
    import coder_pkg::*;
#(
    parameter int unsigned P_PEND_W      = 8,
    parameter int unsigned P_PERIOD_W    = 16,
    parameter int unsigned P_INDEX_STEPS = 1000
) (
    input logic        i_clk,
    input logic        i_rst,
    coder_gen_if.slave bus
);

    logic signed [P_PEND_W-1:0] pending;
    logic                       overflow;
    logic                       take;
    logic                       trans;
    logic                       step_done;
    logic [P_PERIOD_W-1:0]      eff_period;

    coder_state_e          state_q, state_d;
    logic [1:0]            ab_q, ab_d;
    logic                  minus_q, minus_d;
    logic [1:0]            phase_q, phase_d;
    logic [P_PERIOD_W-1:0] period_q, period_d;
    logic [P_PERIOD_W-1:0] timer_q, timer_d;

    coder_gen_pend #(
        .P_PEND_W(P_PEND_W)
    ) u_pend (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_plus    (bus.i_plus_pulse),
        .i_minus   (bus.i_minus_pulse),
        .i_take    (take),
        .i_ovf_clr (bus.i_ovf_clr),
        .o_pending (pending),
        .o_overflow(overflow)
    );

    // Transition timing and step-start decision
    always_comb begin
        trans      = (state_q == StRun) && (timer_q == '0);
        step_done  = trans && (phase_q == 2'd3);
        // A new step starts from IDLE or on the edge that finishes the previous one.
        take       = bus.i_en && (pending != '0) && ((state_q == StIdle) || step_done);
        eff_period = (bus.i_edge_period == '0) ? P_PERIOD_W'(1) : bus.i_edge_period;
    end

    // FSM and quadrature next state
    always_comb begin
        state_d  = state_q;
        ab_d     = ab_q;
        minus_d  = minus_q;
        phase_d  = phase_q;
        period_d = period_q;
        timer_d  = timer_q;

        unique case (state_q)
            StIdle: begin
                if (take) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (trans) begin
                    ab_d    = quad_next(ab_q, minus_q);
                    phase_d = phase_q + 2'd1;
                    timer_d = period_q - P_PERIOD_W'(1);
                    if (step_done && !take) begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q - P_PERIOD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Direction and period are frozen for the whole step.
        if (take) begin
            minus_d  = (pending < 0);
            period_d = eff_period;
            timer_d  = eff_period - P_PERIOD_W'(1);
            phase_d  = 2'd0;
        end
    end

    // FSM registers; reset abandons any partial step
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            ab_q     <= QuadS0;
            minus_q  <= 1'b0;
            phase_q  <= 2'd0;
            period_q <= P_PERIOD_W'(1);
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            ab_q     <= ab_d;
            minus_q  <= minus_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            timer_q  <= timer_d;
        end
    end

    assign bus.o_coder_A  = ab_q[1];
    assign bus.o_coder_B  = ab_q[0];
    assign bus.o_busy     = (state_q == StRun);
    assign bus.o_pending  = pending;
    assign bus.o_overflow = overflow;

`ifdef CODER_GEN_INDEX_EN
    localparam int unsigned PosW = (P_INDEX_STEPS > 1) ? $clog2(P_INDEX_STEPS) : 1;
    localparam logic [PosW-1:0] PosLast = PosW'(P_INDEX_STEPS - 1);

    logic [PosW-1:0]       pos_q, pos_d;
    logic                  z_q, z_d;
    logic [P_PERIOD_W-1:0] z_timer_q, z_timer_d;

    // Position tracking and index pulse timing
    always_comb begin
        pos_d     = pos_q;
        z_d       = z_q;
        z_timer_d = z_timer_q;
        if (z_q) begin
            if (z_timer_q == '0) begin
                z_d = 1'b0;
            end else begin
                z_timer_d = z_timer_q - P_PERIOD_W'(1);
            end
        end
        if (step_done) begin
            if (minus_q) begin
                pos_d = (pos_q == '0) ? PosLast : pos_q - PosW'(1);
            end else begin
                pos_d = (pos_q == PosLast) ? '0 : pos_q + PosW'(1);
            end
            // Z lasts one period of the step that just completed.
            if (pos_d == '0) begin
                z_d       = 1'b1;
                z_timer_d = period_q - P_PERIOD_W'(1);
            end
        end
    end

    // Position and index registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pos_q     <= '0;
            z_q       <= 1'b0;
            z_timer_q <= '0;
        end else begin
            pos_q     <= pos_d;
            z_q       <= z_d;
            z_timer_q <= z_timer_d;
        end
    end

    assign bus.o_coder_Z = z_q;
`else
    logic unused_index_steps;
    assign unused_index_steps = ^P_INDEX_STEPS;
`endif

endmodule
